// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port synchronous SRAM between the
// instruction-fetch port and the EXE-stage data port. Grants one request per
// cycle (data first by default) and steers the one-cycle-late read data back
// to the port that issued the access.
// Optional build macro: SRAM_ARB_FAIR_EN adds a starvation counter that forces
// a fetch grant after STARVE_MAX consecutive denied fetch cycles.
module sram_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic [3:0]        data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_INST = 2'd1,
        R_DRD  = 2'd2,
        R_DWR  = 2'd3
    } resp_state_e;

    resp_state_e state_q, state_d;
    logic        grant_inst;
    logic        grant_data;
    logic        starve_hit;

    // A zero threshold would leave the starvation counter without any bits.
    if (STARVE_MAX == 0) begin : g_bad_starve_max
        $error("sram_port_arbiter: STARVE_MAX must be nonzero");
    end

`ifdef SRAM_ARB_FAIR_EN
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    assign starve_hit = inst_req && (starve_cnt_q == CNT_W'(STARVE_MAX));

    // Count consecutive denied fetch cycles, saturating at the threshold.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!inst_req || grant_inst) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != CNT_W'(STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    // Fixed data-first priority: fetch never overrides a data request.
    assign starve_hit = 1'b0;
`endif

    // Per-cycle grant; nothing is granted while reset is asserted.
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (!reset) begin
            if (inst_req && (starve_hit || !data_req)) begin
                grant_inst = 1'b1;
            end else if (data_req) begin
                grant_data = 1'b1;
            end
        end
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;

    // Forward the granted request straight to the SRAM pins.
    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 4'h0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (grant_data) begin
            sram_en    = 1'b1;
            sram_we    = data_we;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
        end else if (grant_inst) begin
            sram_en    = 1'b1;
            sram_addr  = inst_addr;
        end
    end

    // Response state register: owner of last cycle's grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= R_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next response state follows only this cycle's grant.
    always_comb begin
        state_d = R_IDLE;
        if (grant_inst) begin
            state_d = R_INST;
        end else if (grant_data) begin
            state_d = (data_we == 4'h0) ? R_DRD : R_DWR;
        end
    end

    // Route SRAM read data to the owning port; zero elsewhere.
    always_comb begin
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        data_data_ok = 1'b0;
        data_rdata   = '0;
        case (state_q)
            R_INST: begin
                inst_data_ok = 1'b1;
                inst_rdata   = sram_rdata;
            end
            R_DRD: begin
                data_data_ok = 1'b1;
                data_rdata   = sram_rdata;
            end
            R_DWR: begin
                data_data_ok = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: directed scenarios followed by
// randomized traffic, with an environment SRAM model and a reference model.
module tb_sram_port_arbiter;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STARVE_MAX = 4;
`ifdef SRAM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;
    logic              data_req;
    logic [3:0]        data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;
    logic              sram_en;
    logic [3:0]        sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata = '0;

    sram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          is_inst;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    bit   [31:0] env_mem[bit [31:0]];
    bit   [31:0] ref_mem[bit [31:0]];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          starve = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] we);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    always @(posedge clk) cyc++;

    // Environment SRAM: write-first, read data registered one cycle after enable.
    always @(posedge clk) begin
        logic [31:0] w;
        if (sram_en) begin
            w = env_mem.exists(sram_addr) ? env_mem[sram_addr] : 32'h0;
            w = merge(w, sram_wdata, sram_we);
            if (sram_we != 4'h0) env_mem[sram_addr] = w;
            sram_rdata <= w;
        end else begin
            sram_rdata <= $urandom;
        end
    end

    // Reference model: decide the expected grant, check SRAM pins, queue the response.
    always @(negedge clk) begin
        bit ei, ed;
        if (reset) begin
            starve = 0;
            chk("rst_inst_addr_ok", 32'(inst_addr_ok), 0);
            chk("rst_data_addr_ok", 32'(data_addr_ok), 0);
            chk("rst_sram_en", 32'(sram_en), 0);
        end else begin
            ei = inst_req && (!data_req || (FAIR && starve == int'(STARVE_MAX)));
            ed = data_req && !ei;
            chk("inst_addr_ok", 32'(inst_addr_ok), 32'(ei));
            chk("data_addr_ok", 32'(data_addr_ok), 32'(ed));
            chk("sram_en", 32'(sram_en), 32'(ei || ed));
            if (ed) begin
                chk("sram_we_d", 32'(sram_we), 32'(data_we));
                chk("sram_addr_d", sram_addr, data_addr);
                chk("sram_wdata_d", sram_wdata, data_wdata);
                if (data_we == 4'h0) begin
                    sb_q.push_back('{due: cyc + 1, is_inst: 1'b0, data: ref_rd(data_addr)});
                end else begin
                    ref_mem[data_addr] = merge(ref_rd(data_addr), data_wdata, data_we);
                    sb_q.push_back('{due: cyc + 1, is_inst: 1'b0, data: 32'h0});
                end
            end else if (ei) begin
                chk("sram_we_i", 32'(sram_we), 0);
                chk("sram_addr_i", sram_addr, inst_addr);
                sb_q.push_back('{due: cyc + 1, is_inst: 1'b1, data: ref_rd(inst_addr)});
            end else begin
                chk("sram_idle_we", 32'(sram_we), 0);
                chk("sram_idle_addr", sram_addr, 0);
            end
            if (inst_req && !ei) starve = (starve < int'(STARVE_MAX)) ? starve + 1 : starve;
            else starve = 0;
        end
    end

    // Monitor: pop and compare whenever the DUT presents a response.
    always @(negedge clk) begin
        exp_t e;
        if (!inst_data_ok) chk("inst_rdata_zero", inst_rdata, 0);
        if (!data_data_ok) chk("data_rdata_zero", data_rdata, 0);
        if (reset) begin
            chk("rst_inst_data_ok", 32'(inst_data_ok), 0);
            chk("rst_data_data_ok", 32'(data_data_ok), 0);
        end else if (inst_data_ok || data_data_ok) begin
            chk("single_response", 32'(inst_data_ok && data_data_ok), 0);
            if (sb_q.size() == 0) begin
                chk("unexpected_response", 32'(1), 0);
            end else begin
                e = sb_q.pop_front();
                chk("resp_cycle", 32'(cyc), 32'(e.due));
                chk("resp_port_inst", 32'(inst_data_ok), 32'(e.is_inst));
                chk("resp_rdata", e.is_inst ? inst_rdata : data_rdata, e.data);
            end
        end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            chk("missing_response", 32'(0), 32'(1));
        end
    end

    task automatic idle_inputs();
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_we = 4'h0; data_addr = '0; data_wdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first;
        idle_inputs();
        reset = 1'b1;
        #2;
        chk("reset_sram_en", 32'(sram_en), 0);
        chk("reset_inst_data_ok", 32'(inst_data_ok), 0);
        next_cycle();
        next_cycle();
        reset = 1'b0;

        // Fetch only from a preloaded word.
        env_mem[32'h1c000000] = 32'h12345678;
        ref_mem[32'h1c000000] = 32'h12345678;
        inst_req = 1'b1; inst_addr = 32'h1c000000;
        next_cycle();
        idle_inputs();
        next_cycle();

        // Full-word write then read of the same address on consecutive cycles.
        data_req = 1'b1; data_we = 4'hf; data_addr = 32'h100; data_wdata = 32'hdeadbeef;
        next_cycle();
        data_we = 4'h0; data_wdata = '0;
        next_cycle();
        idle_inputs();
        next_cycle();

        // Conflict: data wins, fetch holds and is granted next cycle.
        inst_req = 1'b1; inst_addr = 32'h1c000000;
        data_req = 1'b1; data_addr = 32'h100;
        next_cycle();
        data_req = 1'b0;
        next_cycle();
        idle_inputs();
        next_cycle();

        // Starvation: continuous data traffic with a held fetch request.
        first = -1;
        inst_req = 1'b1; inst_addr = 32'h1c000000;
        data_req = 1'b1; data_addr = 32'h100;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (inst_addr_ok && first < 0) first = i;
            next_cycle();
            if (first >= 0) inst_req = 1'b0;
            data_addr = 32'(($urandom_range(0, 15)) * 4);
        end
        chk("starve_first_inst_grant", 32'(first), FAIR ? 32'(STARVE_MAX) : 32'hffffffff);
        idle_inputs();
        next_cycle();

        // Reset asserted asynchronously while a data read is in flight.
        data_req = 1'b1; data_addr = 32'h100;
        next_cycle();
        idle_inputs();
        #2;
        reset = 1'b1;
        sb_q.delete();
        #1;
        chk("midflight_data_data_ok", 32'(data_data_ok), 0);
        chk("midflight_sram_en", 32'(sram_en), 0);
        next_cycle();
        reset = 1'b0;
        data_req = 1'b1; data_addr = 32'h100;
        next_cycle();
        idle_inputs();
        next_cycle();

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 2000; i++) begin
            inst_req   = ($urandom_range(0, 99) < 60);
            inst_addr  = 32'(($urandom_range(0, 15)) * 4);
            data_req   = ($urandom_range(0, 99) < 55);
            data_we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            data_addr  = 32'(($urandom_range(0, 15)) * 4);
            data_wdata = $urandom;
            if ($urandom_range(0, 299) == 0) begin
                #2;
                reset = 1'b1;
                sb_q.delete();
                #1;
                chk("rand_rst_ok", 32'(inst_data_ok | data_data_ok | inst_addr_ok | data_addr_ok), 0);
                next_cycle();
                reset = 1'b0;
            end else begin
                next_cycle();
            end
        end

        idle_inputs();
        repeat (3) next_cycle();
        chk("scoreboard_drained", 32'(sb_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one single-port synchronous SRAM between the instruction-fetch port and the EXE-stage data port. It accepts one request per cycle using a req / addr_ok / data_ok handshake and drives the SRAM directly. It also tracks the single in-flight access so the one-cycle-late read data is returned to the port that issued it. It sits between the IF and EXE stages and the data/instruction SRAM in the CPU top level.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive denied inst cycles before inst is forced to win (used only when the fairness feature is enabled)
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- inst_req  input  1  fetch request; held with inst_addr until inst_addr_ok
- inst_addr  input  ADDR_W  fetch address
- inst_addr_ok  output  1  fetch request accepted this cycle (combinational)
- inst_data_ok  output  1  fetch read data valid this cycle
- inst_rdata  output  DATA_W  fetch read data; 0 when inst_data_ok=0
- data_req  input  1  data request; held with its payload until data_addr_ok
- data_we  input  4  byte write enables; 0 = read
- data_addr  input  ADDR_W  data address
- data_wdata  input  DATA_W  store data
- data_addr_ok  output  1  data request accepted this cycle (combinational)
- data_data_ok  output  1  data access complete; read data valid if read
- data_rdata  output  DATA_W  load data; 0 when data_data_ok=0 or the access was a write
- sram_en  output  1  SRAM enable
- sram_we  output  4  SRAM byte write enables
- sram_addr  output  ADDR_W  SRAM address
- sram_wdata  output  DATA_W  SRAM write data
- sram_rdata  input  DATA_W  SRAM read data, valid the cycle after sram_en

## Operation
- Grant is combinational each cycle. At most one of inst_addr_ok or data_addr_ok is high.
- Default priority: data_req beats inst_req.
- Forwarding to SRAM:
  - On a data grant, sram_en=1 and sram_we/addr/wdata come from the data port.
  - On an inst grant, sram_en=1, sram_we=0 and the address comes from the fetch port.
  - With no grant, sram_en=0, sram_we=0, and addr/wdata are 0.
- Response FSM, registered, holding the owner of last cycle's grant. States:
  - R_IDLE: no grant last cycle.
  - R_INST: inst was granted last cycle.
  - R_DRD: data read was granted last cycle.
  - R_DWR: data write was granted last cycle.
- Transitions: next state is chosen purely by the current cycle's grant, so any state can go to any state.
- Response outputs by state:
  - R_INST: inst_data_ok=1, inst_rdata=sram_rdata.
  - R_DRD: data_data_ok=1, data_rdata=sram_rdata.
  - R_DWR: data_data_ok=1, data_rdata=0.
- A new grant is allowed in the same cycle a response is returned, giving full throughput of one access per cycle.
- Reset: the FSM goes to R_IDLE and the starvation counter goes to 0.
  - Every ok output is 0 during reset, and sram_en=0.
  - An in-flight access is dropped and never produces a data_ok.

## Timing
- Request latency: addr_ok is in the same cycle as req; data_ok is exactly 1 cycle after addr_ok, for both ports and for reads and writes.
- Back-to-back:
  - data grants in cycles N and N+1 give data_data_ok in N+1 and N+2.
  - An inst grant in N and a data grant in N+1 give inst_data_ok in N+1 and data_data_ok in N+2.
- Both requests in the same cycle: data is granted and inst waits. inst_addr_ok=0 and the requester must hold.
- A request dropped before addr_ok is legal and has no effect.
- A write followed by a read of the same address in the next cycle returns the new data; this relies on the SRAM being write-first.

## Configuration
- SRAM_ARB_FAIR_EN defined:
  - A counter of width clog2(STARVE_MAX+1) increments each cycle inst_req=1 and inst is not granted, saturating at STARVE_MAX.
  - The counter clears on an inst grant or when inst_req=0.
  - When the counter equals STARVE_MAX and inst_req=1, inst wins over data for that cycle.
- SRAM_ARB_FAIR_EN undefined: no counter; fixed data-first priority always, so fetch may starve under continuous data traffic.

## Test plan
- Inst only: inst_req=1 with addr 0x1c000000, SRAM word 0x12345678 -> inst_addr_ok that cycle; next cycle inst_data_ok=1 with inst_rdata=0x12345678; sram_we=0.
- Data write then read: write we=4'hf to addr 0x100 with 0xdeadbeef, then read 0x100 -> data_data_ok on consecutive cycles; the read returns 0xdeadbeef and the write response has data_rdata=0.
- Conflict: inst_req and data_req both high for 1 cycle -> data_addr_ok=1, inst_addr_ok=0; next cycle inst is granted, and responses return in order D then I.
- Starvation with SRAM_ARB_FAIR_EN and STARVE_MAX=4: data_req held high continuously with inst_req high -> inst granted on the 5th cycle, then data resumes. Without the macro, inst is never granted.
- Reset mid-flight: assert reset asynchronously in the cycle after a data read grant -> data_data_ok never asserts, all ok outputs and sram_en go to 0 immediately, and after release the first grant behaves normally.
